rwt_dac_tx_sequencer: RTL and testbench

Transmit-path controller between the user→DAC async FIFO read side and the 9361 DAC sample port, running entirely in the DAC clock domain. It prefills the FIFO to a programmed level, plays a burst of programmed length (or continuously), and masks disabled lanes. It also detects and counts underflows and flushes stale FIFO contents on abort. The register block drives its control inputs; its status outputs are read back by software.

---
 rtl/rwt_dac_tx_sequencer.sv | 140 ++++++++++++++
 tb/tb_rwt_dac_tx_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rwt_dac_tx_sequencer.sv
// DAC transmit sequencer: prefill, burst/continuous play-out, lane masking, underflow and flush.
// Define RWT_DAC_SEQ_UFLOW_CNT_EN to build the saturating underflow counter.
module rwt_dac_tx_sequencer #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned LEVEL_WIDTH = 10,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   dac_clk,
  input  logic                   dac_rst,
  input  logic                   ctrl_start,
  input  logic                   ctrl_abort,
  input  logic [LEVEL_WIDTH-1:0] ctrl_prefill,
  input  logic [CNT_WIDTH-1:0]   ctrl_burst_len,
  input  logic                   ctrl_uflow_stop,
  input  logic                   fifo_valid,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   fifo_ready,
  input  logic [3:0]             dac_enable,
  input  logic [3:0]             dac_valid,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   dac_underflow,
  output logic [1:0]             stat_state,
  output logic [CNT_WIDTH-1:0]   stat_sample_cnt,
  output logic [15:0]            stat_uflow_cnt,
  output logic                   stat_done
);

  localparam int unsigned LaneW = DATA_WIDTH / 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPrefill = 2'd1,
    StRun     = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   strobe;
  logic                   start_go;
  logic [DATA_WIDTH-1:0]  play_data;
  logic [CNT_WIDTH-1:0]   cnt_next;

  assign strobe     = dac_valid[0];
  assign start_go   = (state_q == StIdle) && ctrl_start && !ctrl_abort;
  assign cnt_next   = stat_sample_cnt + CNT_WIDTH'(1);
  assign stat_state = state_q;

  // Abort beats a same-cycle strobe, so that sample stays in the FIFO.
  assign fifo_ready = (state_q == StFlush) ||
                      ((state_q == StRun) && strobe && !ctrl_abort);

  always_comb begin
    play_data = '0;
    for (int j = 0; j < 4; j++) begin
      if (dac_enable[j] && dac_valid[j]) begin
        play_data[j*LaneW +: LaneW] = fifo_data[j*LaneW +: LaneW];
      end
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q         <= StIdle;
      dac_data        <= '0;
      dac_underflow   <= 1'b0;
      stat_sample_cnt <= '0;
      stat_done       <= 1'b0;
    end else begin
      stat_done <= 1'b0;
      // Default strobe load; the RUN branch overrides it with played data.
      if (strobe) begin
        dac_data      <= '0;
        dac_underflow <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start_go) begin
            state_q         <= StPrefill;
            stat_sample_cnt <= '0;
          end
        end
        StPrefill: begin
          if (ctrl_abort) begin
            state_q <= StFlush;
          end else if (fifo_level >= ctrl_prefill) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (ctrl_abort) begin
            state_q   <= StFlush;
            stat_done <= 1'b1;
          end else if (strobe) begin
            if (fifo_valid) begin
              dac_data        <= play_data;
              stat_sample_cnt <= cnt_next;
              if ((ctrl_burst_len != '0) && (cnt_next == ctrl_burst_len)) begin
                state_q   <= StIdle;
                stat_done <= 1'b1;
              end
            end else begin
              dac_underflow <= 1'b1;
              if (ctrl_uflow_stop) begin
                state_q   <= StFlush;
                stat_done <= 1'b1;
              end
            end
          end
        end
        StFlush: begin
          if (!fifo_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RWT_DAC_SEQ_UFLOW_CNT_EN
  logic        uflow_hit;
  logic [15:0] uflow_cnt_q;

  assign uflow_hit = (state_q == StRun) && strobe && !ctrl_abort && !fifo_valid;

  always_ff @(posedge dac_clk) begin
    if (dac_rst || start_go) begin
      uflow_cnt_q <= '0;
    end else if (uflow_hit && (uflow_cnt_q != 16'hFFFF)) begin
      uflow_cnt_q <= uflow_cnt_q + 16'd1;
    end
  end

  assign stat_uflow_cnt = uflow_cnt_q;
`else
  assign stat_uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_rwt_dac_tx_sequencer.sv
// Scoreboard bench for rwt_dac_tx_sequencer: strobe outputs checked by a monitor against a queue.
module tb_rwt_dac_tx_sequencer;

  localparam int LW = 10;

`ifdef RWT_DAC_SEQ_UFLOW_CNT_EN
  localparam bit UflowEn = 1'b1;
`else
  localparam bit UflowEn = 1'b0;
`endif

  logic        dac_clk = 1'b0;
  logic        dac_rst;
  logic        ctrl_start, ctrl_abort, ctrl_uflow_stop;
  logic [9:0]  ctrl_prefill;
  logic [31:0] ctrl_burst_len;
  logic        fifo_valid, fifo_ready;
  logic [63:0] fifo_data;
  logic [9:0]  fifo_level;
  logic [3:0]  dac_enable, dac_valid;
  logic [63:0] dac_data;
  logic        dac_underflow;
  logic [1:0]  stat_state;
  logic [31:0] stat_sample_cnt;
  logic [15:0] stat_uflow_cnt;
  logic        stat_done;

  rwt_dac_tx_sequencer dut (
    .dac_clk         (dac_clk),
    .dac_rst         (dac_rst),
    .ctrl_start      (ctrl_start),
    .ctrl_abort      (ctrl_abort),
    .ctrl_prefill    (ctrl_prefill),
    .ctrl_burst_len  (ctrl_burst_len),
    .ctrl_uflow_stop (ctrl_uflow_stop),
    .fifo_valid      (fifo_valid),
    .fifo_data       (fifo_data),
    .fifo_level      (fifo_level),
    .fifo_ready      (fifo_ready),
    .dac_enable      (dac_enable),
    .dac_valid       (dac_valid),
    .dac_data        (dac_data),
    .dac_underflow   (dac_underflow),
    .stat_state      (stat_state),
    .stat_sample_cnt (stat_sample_cnt),
    .stat_uflow_cnt  (stat_uflow_cnt),
    .stat_done       (stat_done)
  );

  always #5 dac_clk = ~dac_clk;

  // FIFO read-side model
  logic [63:0] mem [0:1023];
  logic [31:0] wr_ptr = 32'd0;
  logic [31:0] rd_ptr = 32'd0;
  assign fifo_valid = (wr_ptr != rd_ptr);
  assign fifo_level = LW'(wr_ptr - rd_ptr);
  assign fifo_data  = mem[rd_ptr[9:0]];
  always @(posedge dac_clk) if (fifo_ready && fifo_valid) rd_ptr <= rd_ptr + 32'd1;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [64:0] expq [$];
  logic [64:0] exp_e;

  always @(negedge dac_clk) if (stat_done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe edge produces one DAC output word to score.
  always @(posedge dac_clk) begin
    if (dac_valid[0] && !dac_rst) begin
      #1;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h/%0b expected no strobe", dac_data, dac_underflow);
      end else begin
        exp_e = expq.pop_front();
        check("sb_dac_data", dac_data, exp_e[63:0]);
        check("sb_underflow", 64'(dac_underflow), 64'(exp_e[64]));
      end
    end
  end

  function automatic logic [63:0] word_val(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    if (k == 8) return 64'h4444_3333_2222_1111;
    return {16'hA5A5 ^ kk, kk + 16'h0300, kk + 16'h0100, kk};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge dac_clk);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[9:0]] = word_val(int'(wr_ptr));
      wr_ptr = wr_ptr + 32'd1;
    end
  endtask

  task automatic strobe_n(input logic [63:0] d, input logic u);
    expq.push_back({u, d});
    dac_valid = 4'hF;
    tick(1);
    dac_valid = 4'h0;
  endtask

  task automatic strobe(input logic [63:0] d, input logic u);
    strobe_n(d, u);
    tick(1);
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1;
    tick(1);
    ctrl_start = 1'b0;
  endtask

  task automatic pulse_abort();
    ctrl_abort = 1'b1;
    tick(1);
    ctrl_abort = 1'b0;
  endtask

  int d0;
  logic [31:0] p0;

  initial begin
    dac_rst = 1'b1; ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_uflow_stop = 1'b0;
    ctrl_prefill = 10'd0; ctrl_burst_len = 32'd0; dac_enable = 4'hF; dac_valid = 4'h0;
    tick(3);
    check("rst_state", 64'(stat_state), 64'd0);
    check("rst_dac_data", dac_data, 64'd0);
    check("rst_underflow", 64'(dac_underflow), 64'd0);
    check("rst_sample_cnt", 64'(stat_sample_cnt), 64'd0);
    check("rst_uflow_cnt", 64'(stat_uflow_cnt), 64'd0);
    check("rst_done", 64'(stat_done), 64'd0);
    check("rst_fifo_ready", 64'(fifo_ready), 64'd0);
    dac_rst = 1'b0;
    tick(1);

    // Basic burst: prefill 4, length 8, 16 words
    ctrl_prefill = 10'd4; ctrl_burst_len = 32'd8;
    push_words(2);
    pulse_start();
    check("basic_prefill", 64'(stat_state), 64'd1);
    tick(2);
    check("basic_wait_level", 64'(stat_state), 64'd1);
    push_words(14);
    tick(1);
    check("basic_run", 64'(stat_state), 64'd2);
    d0 = done_cnt; p0 = rd_ptr;
    for (int i = 0; i < 8; i++) strobe(word_val(i), 1'b0);
    check("basic_done_once", 64'(done_cnt - d0), 64'd1);
    check("basic_idle", 64'(stat_state), 64'd0);
    check("basic_sample_cnt", 64'(stat_sample_cnt), 64'd8);
    check("basic_pops", 64'(rd_ptr - p0), 64'd8);
    check("basic_level_left", 64'(fifo_level), 64'd8);
    strobe(64'd0, 1'b0);

    // Lane masking, prefill 0, single-sample burst
    dac_enable = 4'b0101; ctrl_prefill = 10'd0; ctrl_burst_len = 32'd1;
    pulse_start();
    check("mask_prefill_1cyc", 64'(stat_state), 64'd1);
    tick(1);
    check("mask_run", 64'(stat_state), 64'd2);
    strobe(64'h0000_3333_0000_1111, 1'b0);
    check("mask_idle", 64'(stat_state), 64'd0);
    dac_enable = 4'hF;

    // Abort mid-RUN with 20 words queued
    push_words(15);
    ctrl_prefill = 10'd4; ctrl_burst_len = 32'd0;
    pulse_start();
    tick(1);
    check("abort_run", 64'(stat_state), 64'd2);
    strobe(word_val(9), 1'b0);
    strobe(word_val(10), 1'b0);
    check("abort_queued", 64'(fifo_level), 64'd20);
    pulse_abort();
    check("abort_flush", 64'(stat_state), 64'd3);
    check("abort_done", 64'(stat_done), 64'd1);
    check("abort_fifo_ready", 64'(fifo_ready), 64'd1);
    p0 = rd_ptr;
    tick(20);
    check("abort_flush_pops", 64'(rd_ptr - p0), 64'd20);
    check("abort_still_flush", 64'(stat_state), 64'd3);
    tick(1);
    check("abort_idle", 64'(stat_state), 64'd0);
    ctrl_start = 1'b1; ctrl_abort = 1'b1;
    tick(1);
    ctrl_start = 1'b0; ctrl_abort = 1'b0;
    check("start_abort_idle", 64'(stat_state), 64'd0);
    tick(1);
    check("start_abort_idle2", 64'(stat_state), 64'd0);

    // Underflow, continue
    ctrl_prefill = 10'd3; ctrl_uflow_stop = 1'b0;
    push_words(3);
    pulse_start();
    tick(1);
    check("ufc_run", 64'(stat_state), 64'd2);
    for (int i = 31; i < 34; i++) strobe(word_val(i), 1'b0);
    for (int i = 0; i < 3; i++) strobe(64'd0, 1'b1);
    check("ufc_uflow_hold", 64'(dac_underflow), 64'd1);
    check("ufc_uflow_cnt", 64'(stat_uflow_cnt), UflowEn ? 64'd3 : 64'd0);
    check("ufc_still_run", 64'(stat_state), 64'd2);
    push_words(2);
    strobe(word_val(34), 1'b0);
    check("ufc_sample_cnt", 64'(stat_sample_cnt), 64'd4);
    pulse_abort();
    tick(2);
    check("ufc_idle", 64'(stat_state), 64'd0);
    check("ufc_flushed", 64'(fifo_level), 64'd0);

    // Underflow, stop
    ctrl_prefill = 10'd1; ctrl_uflow_stop = 1'b1;
    push_words(1);
    pulse_start();
    tick(1);
    check("ufs_cnt_cleared", 64'(stat_uflow_cnt), 64'd0);
    strobe(word_val(36), 1'b0);
    d0 = done_cnt;
    strobe_n(64'd0, 1'b1);
    check("ufs_flush", 64'(stat_state), 64'd3);
    check("ufs_done", 64'(stat_done), 64'd1);
    tick(1);
    check("ufs_idle", 64'(stat_state), 64'd0);
    check("ufs_done_once", 64'(done_cnt - d0), 64'd1);
    check("ufs_uflow_cnt", 64'(stat_uflow_cnt), UflowEn ? 64'd1 : 64'd0);

    // Reset mid-RUN
    ctrl_uflow_stop = 1'b0;
    push_words(4);
    pulse_start();
    tick(1);
    strobe(word_val(37), 1'b0);
    check("rstrun_sample_cnt", 64'(stat_sample_cnt), 64'd1);
    dac_rst = 1'b1;
    tick(1);
    dac_rst = 1'b0;
    check("rstrun_state", 64'(stat_state), 64'd0);
    check("rstrun_dac_data", dac_data, 64'd0);
    check("rstrun_sample_cnt0", 64'(stat_sample_cnt), 64'd0);
    check("rstrun_fifo_ready", 64'(fifo_ready), 64'd0);
    check("rstrun_fifo_kept", 64'(fifo_level), 64'd3);
    tick(1);

    // Saturation: drain stale words, then 70000 consecutive underflows
    pulse_start();
    tick(1);
    pulse_abort();
    tick(4);
    check("sat_drained", 64'(fifo_level), 64'd0);
    ctrl_prefill = 10'd0;
    pulse_start();
    tick(1);
    check("sat_run", 64'(stat_state), 64'd2);
    dac_valid = 4'hF;
    for (int i = 0; i < 70000; i++) begin
      expq.push_back({1'b1, 64'd0});
      tick(1);
    end
    dac_valid = 4'h0;
    tick(1);
    check("sat_uflow_cnt", 64'(stat_uflow_cnt), UflowEn ? 64'hFFFF : 64'd0);
    check("sat_still_run", 64'(stat_state), 64'd2);
    pulse_abort();
    tick(1);
    check("sat_idle", 64'(stat_state), 64'd0);

    tick(2);
    check("sb_drain", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
